// File: rtl/mul_div_if.sv
// mul_div_if: request/result bundle between the execute stage and the multiply/divide unit.
interface mul_div_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_1;
    logic [WIDTH-1:0] op_2;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, op_1, op_2, flush, input busy, done, div_zero, hi, lo);
    modport slave (input start, op, op_1, op_2, flush, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO with HI/LO registers and a start/busy/done handshake.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    mul_div_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t             state, nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] p, p_fix;
    logic [WIDTH-1:0]   a, m1, m2, q_fix, r_fix, hi, lo;
    logic [WIDTH:0]     msum, dtry;
    logic               is_div, neg_p, neg_r, dz, done, div_zero, sgn, req;
    assign bus.busy     = state != IDLE;
    assign bus.done     = done;
    assign bus.div_zero = div_zero;
    assign bus.hi       = hi;
    assign bus.lo       = lo;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end
    // p holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        sgn   = !bus.op[0];
        req   = bus.start && !bus.op[2];
        m1    = (sgn && bus.op_1[WIDTH-1]) ? -bus.op_1 : bus.op_1;
        m2    = (sgn && bus.op_2[WIDTH-1]) ? -bus.op_2 : bus.op_2;
        msum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : '0);
        dtry  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} - {1'b0, a};
        p_fix = neg_p ? -p : p;
        q_fix = dz ? '1 : (neg_p ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
        r_fix = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
        nxt   = (state == IDLE) ? (req ? RUN : IDLE) :
                (bus.flush || state == FIX) ? IDLE :
                (cnt == CNT_W'(WIDTH - 1)) ? FIX : RUN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            p        <= '0;
            a        <= '0;
            is_div   <= 1'b0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (state == IDLE && bus.start) begin
                if (bus.op == 3'b100) hi <= bus.op_1;
                if (bus.op == 3'b101) lo <= bus.op_1;
                if (req) begin
                    cnt    <= '0;
                    is_div <= bus.op[1];
                    neg_p  <= sgn && (bus.op_1[WIDTH-1] ^ bus.op_2[WIDTH-1]);
                    neg_r  <= sgn && bus.op_1[WIDTH-1];
                    dz     <= bus.op_2 == '0;
                    p      <= {{WIDTH{1'b0}}, bus.op[1] ? m1 : m2};
                    a      <= bus.op[1] ? m2 : m1;
                end
            end else if (state == RUN && !bus.flush) begin
                cnt <= cnt + 1'b1;
                p   <= !is_div ? {msum, p[WIDTH-1:1]} :
                       dtry[WIDTH] ? {p[2*WIDTH-2:0], 1'b0} :
                       {dtry[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
            end else if (state == FIX && !bus.flush) begin
                hi       <= is_div ? r_fix : p_fix[2*WIDTH-1:WIDTH];
                lo       <= is_div ? q_fix : p_fix[WIDTH-1:0];
                div_zero <= is_div && dz;
                done     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed checks of the multiply/divide unit at WIDTH=32.
module tb_mul_div_unit;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    mul_div_if #(.WIDTH(W)) bus ();
    mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic b0, output int n);
        bus.start = 1'b1;
        bus.op    = o;
        bus.op_1  = x;
        bus.op_2  = y;
        tick();
        bus.start = 1'b0;
        b0 = bus.busy;
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b exp 0", bus.div_zero); end
        checks++; if ({bus.hi, bus.lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h exp 0", {bus.hi, bus.lo}); end
    endtask

    task automatic test_mult();
        logic b0;
        int n;
        run_op(3'b000, 32'hFFFFFFFD, 32'd5, b0, n);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL mult_busy got %b exp 1", b0); end
        checks++; if (n != W + 1) begin errors++; $display("FAIL mult_latency got %0d exp %0d", n, W + 1); end
        checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_neg got %h exp FFFFFFFFFFFFFFF1", {bus.hi, bus.lo}); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_done got %b exp 0", bus.busy); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", bus.done); end
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, b0, n);
        checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_max got %h exp FFFFFFFE00000001", {bus.hi, bus.lo}); end
        tick();
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, b0, n);
        checks++; if ({bus.hi, bus.lo} !== 64'h1) begin errors++; $display("FAIL mult_negneg got %h exp 1", {bus.hi, bus.lo}); end
        tick();
    endtask

    task automatic test_div();
        logic b0;
        int n;
        run_op(3'b010, 32'hFFFFFFF9, 32'd2, b0, n);
        checks++; if (n != W + 1) begin errors++; $display("FAIL div_latency got %0d exp %0d", n, W + 1); end
        checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg got %h exp FFFFFFFFFFFFFFFD", {bus.hi, bus.lo}); end
        tick();
        run_op(3'b010, 32'd7, 32'hFFFFFFFE, b0, n);
        checks++; if ({bus.hi, bus.lo} !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL div_negdivisor got %h exp 00000001FFFFFFFD", {bus.hi, bus.lo}); end
        tick();
        run_op(3'b011, 32'd7, 32'd2, b0, n);
        checks++; if ({bus.hi, bus.lo} !== 64'h00000001_00000003) begin errors++; $display("FAIL divu got %h exp 0000000100000003", {bus.hi, bus.lo}); end
        tick();
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, b0, n);
        checks++; if ({bus.hi, bus.lo} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_ovf got %h exp 0000000080000000", {bus.hi, bus.lo}); end
        checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_dz got %b exp 0", bus.div_zero); end
        tick();
    endtask

    task automatic test_div_zero();
        logic b0;
        int n;
        run_op(3'b011, 32'd7, 32'd0, b0, n);
        checks++; if (n != W + 1) begin errors++; $display("FAIL dz_latency got %0d exp %0d", n, W + 1); end
        checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b exp 1", bus.div_zero); end
        checks++; if ({bus.hi, bus.lo} !== 64'h00000007_FFFFFFFF) begin errors++; $display("FAIL divu_zero got %h exp 00000007FFFFFFFF", {bus.hi, bus.lo}); end
        tick();
        checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got %b exp 0", bus.div_zero); end
        run_op(3'b010, 32'hFFFFFFF8, 32'd0, b0, n);
        checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFF8_FFFFFFFF) begin errors++; $display("FAIL div_zero_neg got %h exp FFFFFFF8FFFFFFFF", {bus.hi, bus.lo}); end
        tick();
    endtask

    task automatic test_mthi_mtlo();
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.op_1  = 32'h12345678;
        tick();
        checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi got %h exp 12345678", bus.hi); end
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL mthi_flags got %b exp 00", {bus.busy, bus.done}); end
        bus.op   = 3'b101;
        bus.op_1 = 32'h9ABCDEF0;
        tick();
        bus.start = 1'b0;
        checks++; if ({bus.hi, bus.lo} !== 64'h12345678_9ABCDEF0) begin errors++; $display("FAIL mtlo got %h exp 123456789ABCDEF0", {bus.hi, bus.lo}); end
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL mtlo_flags got %b exp 00", {bus.busy, bus.done}); end
        bus.start = 1'b1;
        bus.op    = 3'b110;
        bus.op_1  = 32'h55555555;
        tick();
        bus.start = 1'b0;
        checks++; if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 64'h12345678_9ABCDEF0}) begin errors++; $display("FAIL reserved got %h exp 0123456789ABCDEF0", {bus.busy, bus.hi, bus.lo}); end
    endtask

    task automatic test_flush();
        int seen = 0;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.op_1  = 32'd3;
        bus.op_2  = 32'd4;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.op_1  = 32'h0000DEAD;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi_busy got %h exp 12345678", bus.hi); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_prebusy got %b exp 1", bus.busy); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", bus.busy); end
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_done got %0d exp 0", seen); end
        checks++; if ({bus.hi, bus.lo} !== 64'h12345678_9ABCDEF0) begin errors++; $display("FAIL flush_hilo got %h exp 123456789ABCDEF0", {bus.hi, bus.lo}); end
    endtask

    task automatic test_back_to_back();
        logic b0;
        int n;
        run_op(3'b001, 32'd6, 32'd7, b0, n);
        checks++; if ({bus.done, bus.hi, bus.lo} !== {1'b1, 64'd42}) begin errors++; $display("FAIL b2b_first got %h exp 1000000000000002A", {bus.done, bus.hi, bus.lo}); end
        run_op(3'b001, 32'd3, 32'd5, b0, n);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", b0); end
        checks++; if (n != W + 1) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", n, W + 1); end
        checks++; if ({bus.hi, bus.lo} !== 64'd15) begin errors++; $display("FAIL b2b_second got %h exp F", {bus.hi, bus.lo}); end
        tick();
    endtask

    task automatic test_async_reset();
        int seen = 0;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.op_1  = 32'd9;
        bus.op_2  = 32'd9;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'h0) begin errors++; $display("FAIL async_reset got %h exp 0", {bus.busy, bus.done, bus.hi, bus.lo}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL post_reset_activity got %0d exp 0", seen); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.op_1  = '0;
        bus.op_2  = '0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO result registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the single-cycle ALU in the execute stage and generalises it in two ways: the datapath width is a parameter, and results take multiple cycles, sequenced by a start/busy/done handshake. The pipeline stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand/HI/LO width; even, >= 4
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
op_1  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
op_2  input  WIDTH  multiplier / divisor
flush  input  1  synchronous abort of the operation in flight
busy  output  1  operation in flight; new requests ignored
done  output  1  one-cycle pulse; hi/lo hold the new result
div_zero  output  1  valid with done; divisor was 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0, internal accumulators=0. Reset mid-operation discards the operation. There is no done pulse after reset releases.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op=MTHI/MTLO: hi (resp. lo) <= op_1 at that edge. The state stays IDLE; busy and done stay 0.
- IDLE, start=1, op reserved: no effect.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU: latch the operands and the operation, then go to RUN with counter=0 and busy=1.
  - Signed ops store operand magnitudes plus the result sign bits. Negation is two's complement in WIDTH bits.
- RUN: one iteration per cycle. The counter increments, and after WIDTH iterations the state goes to FIX.
  - Multiply: shift-add over a 2*WIDTH product.
  - Divide: restoring shift-subtract.
- FIX: apply the sign correction, then write hi/lo.
  - Multiply: {hi,lo} <= product, negated over 2*WIDTH if sign(op_1) XOR sign(op_2).
  - Divide: lo <= quotient, truncated toward zero; hi <= remainder, carrying the sign of the dividend.
  - Next state IDLE. done=1 and busy=0 in the following cycle.
- Latency: start sampled at edge E. hi/lo update at edge E+WIDTH+1. done=1 during the cycle after E+WIDTH+1. busy=1 from E through E+WIDTH+1.
- Back-to-back: start may be asserted in the same cycle done=1. That cycle is IDLE, so the request is accepted.
- start while busy=1: ignored and not queued. This applies to MTHI/MTLO as well.
- Divide by zero (op_2=0, DIV or DIVU): full latency, no special path.
  - Result: lo=all ones, hi=op_1 unchanged (original signed value for DIV).
  - div_zero=1 together with done; div_zero is cleared on the next cycle.
- Signed overflow, DIV most-negative / -1: lo=most-negative, hi=0. No flag.
- flush=1 in RUN or FIX: return to IDLE at that edge. hi/lo are unchanged and no done pulse is produced. flush in IDLE has no effect. flush has priority over start.
- Widths: all internal products are 2*WIDTH bits. Remainder and quotient are WIDTH bits. There is no saturation.
- hi/lo change only on FIX writes, MTHI/MTLO, and reset.

Test Plan:
- WIDTH=32, MULT op_1=0xFFFFFFFD (-3), op_2=5 -> done at start+34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- DIVU 7/0 -> done with div_zero=1, lo=0xFFFFFFFF, hi=7. div_zero=0 the next cycle.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge after each request; busy and done never asserted.
- MULT accepted, then at +5 cycles: start MTHI 0xDEAD (ignored), then flush=1 -> busy drops next cycle, no done, hi/lo keep their prior values. A new MULTU issued in the same cycle as a done pulse is accepted.
- rst_n pulled low asynchronously mid-RUN at cycle +10 -> busy, done, hi and lo go to 0 immediately. After release, no done pulse appears within 40 cycles.
